// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM ownership handover logic.
// Used by the scheduler and its cycle counter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    TO_CAM    = 3'd0,
    CAM_RUN   = 3'd1,
    CAM_DRAIN = 3'd2,
    TO_NIOS   = 3'd3,
    NIOS_RUN  = 3'd4
  } handover_state_t;

  localparam int DEF_MIN_CAM_CYCLES = 1024;
  localparam int DEF_LEASE_CYCLES   = 65535;
  localparam int DEF_ACK_TIMEOUT    = 15;
  localparam int DEF_CNT_W          = 16;
  localparam int HANDOVER_CNT_W     = 8;

endpackage

// File: rtl/sat_cycle_counter.sv
// Up-counter with synchronous clear that holds at a run-time limit.
// tc is high whenever the count has reached the limit.
module sat_cycle_counter
  import sdram_arb_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count >= limit);

endmodule

// File: rtl/sdram_handover_scheduler.sv
// Hands SDRAM ownership between the camera path and Nios at frame boundaries,
// driving the ownership arbiter and bounding Nios ownership with a lease.
module sdram_handover_scheduler
  import sdram_arb_pkg::*;
#(
  parameter int MIN_CAM_CYCLES = DEF_MIN_CAM_CYCLES,
  parameter int LEASE_CYCLES   = DEF_LEASE_CYCLES,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      nios_req,
  output logic                      nios_grant,
  input  logic                      cam_frame_end,
  input  logic                      cam_idle,
  output logic                      cam_pause,
  output logic                      RequestNiosControl,
  input  logic                      NiosHasControl,
  input  logic                      CamHasControl,
  output logic                      lease_expired,
  output logic                      ack_error,
  output logic [HANDOVER_CNT_W-1:0] handover_count
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  handover_state_t state;
  logic            frame_seen;
  logic            rearm;

  logic             cyc_clr;
  logic             cyc_en;
  logic [CNT_W-1:0] cyc_limit;
  logic             cyc_tc;

  logic             ack_waiting;
  logic             ack_seen;
  logic             ack_tc;
  logic             frame_hit;

  // One counter serves both phases: camera minimum while the camera owns
  // SDRAM, lease length while Nios does. The handshake states clear it.
  always_comb begin
    cyc_clr     = (state == TO_CAM) || (state == TO_NIOS);
    cyc_en      = (state == CAM_RUN) || (state == NIOS_RUN);
    cyc_limit   = (state == NIOS_RUN) ? CNT_W'(LEASE_CYCLES - 1) : CNT_W'(MIN_CAM_CYCLES);
    ack_waiting = (state == TO_CAM) || (state == TO_NIOS);
    ack_seen    = (state == TO_NIOS) ? NiosHasControl : CamHasControl;
    frame_hit   = frame_seen | cam_frame_end;
  end

  sat_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (Reset),
    .clr   (cyc_clr),
    .en    (cyc_en),
    .limit (cyc_limit),
    .tc    (cyc_tc)
  );

  sat_cycle_counter #(.W(ACK_W)) u_ack_cnt (
    .clk   (clk),
    .rst   (Reset),
    .clr   (!ack_waiting),
    .en    (ack_waiting),
    .limit (ACK_W'(ACK_TIMEOUT - 1)),
    .tc    (ack_tc)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state              <= TO_CAM;
      RequestNiosControl <= 1'b0;
      cam_pause          <= 1'b1;
      nios_grant         <= 1'b0;
      lease_expired      <= 1'b0;
      ack_error          <= 1'b0;
      handover_count     <= '0;
      frame_seen         <= 1'b0;
      rearm              <= 1'b1;
    end else begin
      lease_expired <= 1'b0;
      if (!nios_req) begin
        rearm <= 1'b1;
      end
      // Sticky: the request level is left alone, we just keep waiting.
      if (ack_waiting && ack_tc && !ack_seen) begin
        ack_error <= 1'b1;
      end

      case (state)
        TO_CAM: begin
          if (CamHasControl) begin
            state     <= CAM_RUN;
            cam_pause <= 1'b0;
          end
        end
        CAM_RUN: begin
          if (nios_req && rearm && cyc_tc) begin
            state      <= CAM_DRAIN;
            frame_seen <= cam_frame_end;
            cam_pause  <= cam_frame_end;
          end
        end
        CAM_DRAIN: begin
          if (!nios_req) begin
            state      <= CAM_RUN;
            frame_seen <= 1'b0;
            cam_pause  <= 1'b0;
          end else if (frame_hit && cam_idle) begin
            state              <= TO_NIOS;
            frame_seen         <= 1'b0;
            cam_pause          <= 1'b1;
            RequestNiosControl <= 1'b1;
          end else if (cam_frame_end) begin
            frame_seen <= 1'b1;
            cam_pause  <= 1'b1;
          end
        end
        TO_NIOS: begin
          if (NiosHasControl) begin
            state          <= NIOS_RUN;
            nios_grant     <= 1'b1;
            handover_count <= handover_count + 1'b1;
          end
        end
        NIOS_RUN: begin
          // A release in the expiry cycle takes precedence over the lease pulse.
          if (!nios_req) begin
            state              <= TO_CAM;
            nios_grant         <= 1'b0;
            RequestNiosControl <= 1'b0;
          end else if (cyc_tc) begin
            state              <= TO_CAM;
            nios_grant         <= 1'b0;
            RequestNiosControl <= 1'b0;
            lease_expired      <= 1'b1;
            rearm              <= 1'b0;
          end
        end
        default: begin
          state <= TO_CAM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_handover_scheduler.sv
// Directed bench: a 3-cycle arbiter model closes the loop, and a scoreboard
// matches every output edge against hand-computed (name, cycle, value) entries.
module tb_sdram_handover_scheduler;

  logic       clk;
  logic       Reset;
  logic       nios_req;
  logic       nios_grant;
  logic       cam_frame_end;
  logic       cam_idle;
  logic       cam_pause;
  logic       RequestNiosControl;
  logic       NiosHasControl;
  logic       CamHasControl;
  logic       lease_expired;
  logic       ack_error;
  logic [7:0] handover_count;
  logic       ack_block;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  typedef struct {
    string name;
    int    cyc;
    int    val;
  } ev_t;
  ev_t exp_q[$];

  sdram_handover_scheduler #(
    .MIN_CAM_CYCLES (8),
    .LEASE_CYCLES   (16),
    .ACK_TIMEOUT    (15),
    .CNT_W          (16)
  ) dut (
    .clk                (clk),
    .Reset              (Reset),
    .nios_req           (nios_req),
    .nios_grant         (nios_grant),
    .cam_frame_end      (cam_frame_end),
    .cam_idle           (cam_idle),
    .cam_pause          (cam_pause),
    .RequestNiosControl (RequestNiosControl),
    .NiosHasControl     (NiosHasControl),
    .CamHasControl      (CamHasControl),
    .lease_expired      (lease_expired),
    .ack_error          (ack_error),
    .handover_count     (handover_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter model: ownership status follows the request three cycles later.
  logic [1:0] arb_s0, arb_s1, arb_s2;  // {nios, cam}
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      arb_s0 <= 2'b00;
      arb_s1 <= 2'b00;
      arb_s2 <= 2'b00;
    end else begin
      arb_s0 <= {RequestNiosControl, !RequestNiosControl};
      arb_s1 <= arb_s0;
      arb_s2 <= arb_s1;
    end
  end
  assign NiosHasControl = arb_s2[1] & !ack_block;
  assign CamHasControl  = arb_s2[0];

  task automatic expect_ev(input string n, input int c, input int v);
    ev_t e;
    e.name = n;
    e.cyc  = base + c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string n, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s: got %0d at cycle %0d, required no event", n, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.name != n || e.cyc != cyc || e.val != v) begin
        bad++;
        $display("FAIL %s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 e.name, n, v, cyc, e.name, e.val, e.cyc);
      end else begin
        $display("ok   %s=%0d at cycle %0d", n, v, cyc);
      end
    end
  endtask

  task automatic check(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", n, act, req);
    end else begin
      $display("ok   %s=%0d", n, act);
    end
  endtask

  task automatic at(input int c);
    while (cyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: report every output edge to the scoreboard, away from the active edge.
  logic p_req, p_grant, p_pause, p_lease, p_ackerr;
  always @(negedge clk) begin
    if (!Reset) begin
      if (RequestNiosControl !== p_req) observe("req", int'(RequestNiosControl));
      if (nios_grant !== p_grant) begin
        observe("grant", int'(nios_grant));
        if (nios_grant) observe("hcnt", int'(handover_count));
      end
      if (cam_pause !== p_pause) observe("pause", int'(cam_pause));
      if (lease_expired !== p_lease) observe("lease", int'(lease_expired));
      if (ack_error !== p_ackerr) observe("ackerr", int'(ack_error));
    end
    p_req    = RequestNiosControl;
    p_grant  = nios_grant;
    p_pause  = cam_pause;
    p_lease  = lease_expired;
    p_ackerr = ack_error;
  end

  initial begin
    Reset         = 1'b1;
    nios_req      = 1'b0;
    cam_frame_end = 1'b0;
    cam_idle      = 1'b1;
    ack_block     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",    int'(RequestNiosControl), 0);
    check("rst_pause",  int'(cam_pause), 1);
    check("rst_grant",  int'(nios_grant), 0);
    check("rst_lease",  int'(lease_expired), 0);
    check("rst_ackerr", int'(ack_error), 0);
    check("rst_hcnt",   int'(handover_count), 0);

    // Reset release, normal handover, lease expiry.
    base  = cyc;
    Reset = 1'b0;
    expect_ev("pause", 4, 0);
    expect_ev("req",   21, 1);
    expect_ev("pause", 21, 1);
    expect_ev("grant", 25, 1);
    expect_ev("hcnt",  25, 1);
    expect_ev("req",   41, 0);
    expect_ev("grant", 41, 0);
    expect_ev("lease", 41, 1);
    expect_ev("lease", 42, 0);
    expect_ev("pause", 45, 0);
    at(2);  nios_req = 1'b1;
    at(20); cam_frame_end = 1'b1;
    at(21); cam_frame_end = 1'b0;

    // Request held after expiry: no regrant until it toggles; then abort in drain.
    at(70); nios_req = 1'b0;
    at(71); nios_req = 1'b1;
    expect_ev("pause", 74, 1);
    expect_ev("pause", 76, 0);
    at(73); cam_idle = 1'b0; cam_frame_end = 1'b1;
    at(74); cam_frame_end = 1'b0;
    at(75); nios_req = 1'b0;
    at(76); cam_idle = 1'b1;

    // Ack timeout, late acknowledge, release coinciding with lease expiry.
    expect_ev("req",    83, 1);
    expect_ev("pause",  83, 1);
    expect_ev("ackerr", 98, 1);
    expect_ev("grant",  101, 1);
    expect_ev("hcnt",   101, 2);
    expect_ev("req",    117, 0);
    expect_ev("grant",  117, 0);
    expect_ev("pause",  121, 0);
    at(80);  nios_req = 1'b1; ack_block = 1'b1;
    at(82);  cam_frame_end = 1'b1;
    at(83);  cam_frame_end = 1'b0;
    at(100); ack_block = 1'b0;
    at(116); nios_req = 1'b0;

    // Request dropped while waiting in TO_NIOS: one-cycle grant.
    expect_ev("req",   132, 1);
    expect_ev("pause", 132, 1);
    expect_ev("grant", 136, 1);
    expect_ev("hcnt",  136, 3);
    expect_ev("req",   137, 0);
    expect_ev("grant", 137, 0);
    expect_ev("pause", 141, 0);
    at(125); nios_req = 1'b1;
    at(131); cam_frame_end = 1'b1;
    at(132); cam_frame_end = 1'b0;
    at(133); nios_req = 1'b0;

    // Another handover, then asynchronous reset mid-lease.
    expect_ev("req",   152, 1);
    expect_ev("pause", 152, 1);
    expect_ev("grant", 156, 1);
    expect_ev("hcnt",  156, 4);
    at(141); nios_req = 1'b1;
    at(151); cam_frame_end = 1'b1;
    at(152); cam_frame_end = 1'b0;
    at(160);
    check("pre_rst_grant", int'(nios_grant), 1);
    #2;
    Reset    = 1'b1;
    nios_req = 1'b0;
    #1;
    check("async_grant",  int'(nios_grant), 0);
    check("async_req",    int'(RequestNiosControl), 0);
    check("async_hcnt",   int'(handover_count), 0);
    check("async_ackerr", int'(ack_error), 0);
    check("async_pause",  int'(cam_pause), 1);
    at(163); Reset = 1'b0;
    expect_ev("pause", 167, 0);
    at(175);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing %s: got no event, required %s=%0d at cycle %0d", e.name, e.name, e.val, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_handover_scheduler.md
# sdram_handover_scheduler

Sequences SDRAM ownership handovers between the camera capture path and the Nios processor. Sits upstream of the SDRAM ownership arbiter: drives its `RequestNiosControl` input and reads back its `NiosHasControl`/`CamHasControl` status. Handovers to Nios happen only at camera frame boundaries with the camera write path drained. Nios ownership is bounded by a lease timer.

## Interface
- `MIN_CAM_CYCLES`, default 1024: minimum cycles in `CAM_RUN` before a Nios request is considered.
- `LEASE_CYCLES`, default 65535: maximum Nios ownership in cycles.
- `ACK_TIMEOUT`, default 15: maximum cycles to wait for an arbiter acknowledge.
- `CNT_W`, default 16: width of the cycle counter. Must hold `max(MIN_CAM_CYCLES, LEASE_CYCLES)`.

Ports:
- `clk` in 1: single clock, shared with the arbiter.
- `Reset` in 1: asynchronous, active-high.
- `nios_req` in 1: level; Nios wants SDRAM. Deassert to release.
- `nios_grant` out 1: Nios may issue SDRAM accesses.
- `cam_frame_end` in 1: single-cycle pulse at the end of a camera frame.
- `cam_idle` in 1: level; camera write FIFO is empty and no burst is in flight.
- `cam_pause` out 1: camera must not start a new frame.
- `RequestNiosControl` out 1: to the arbiter.
- `NiosHasControl` in 1: from the arbiter.
- `CamHasControl` in 1: from the arbiter.
- `lease_expired` out 1: one-cycle pulse when the lease times out.
- `ack_error` out 1: sticky; set on arbiter acknowledge timeout, cleared only by `Reset`.
- `handover_count` out 8: count of completed Nios grants; wraps 255→0.

## Operation
States: `TO_CAM`, `CAM_RUN`, `CAM_DRAIN`, `TO_NIOS`, `NIOS_RUN`.

Reset state is `TO_CAM`. Reset values:
- `RequestNiosControl`=0, `cam_pause`=1
- `nios_grant`=0, `lease_expired`=0, `ack_error`=0, `handover_count`=0
- counter=0, `frame_seen`=0, `rearm`=1

State behaviour:
- **TO_CAM**: `RequestNiosControl`=0, `cam_pause`=1. Go to `CAM_RUN` when `CamHasControl`=1; the counter clears on entry to `CAM_RUN`.
- **CAM_RUN**: counter increments and saturates at `MIN_CAM_CYCLES`. Go to `CAM_DRAIN` when `nios_req`=1, `rearm`=1 and counter ≥ `MIN_CAM_CYCLES`.
- **CAM_DRAIN**:
  - `cam_frame_end` sets `frame_seen`; a pulse in the entry cycle counts.
  - `cam_pause` = `frame_seen`.
  - When `frame_seen`=1 and `cam_idle`=1, go to `TO_NIOS`.
  - If `nios_req` drops first, return to `CAM_RUN`: clear `frame_seen`, deassert `cam_pause`, keep the counter value.
- **TO_NIOS**: `RequestNiosControl`=1, `cam_pause`=1. Go to `NIOS_RUN` when `NiosHasControl`=1; increment `handover_count` and clear the counter.
- **NIOS_RUN**:
  - `nios_grant`=1, counter increments.
  - If `nios_req`=0, go to `TO_CAM`.
  - Otherwise, if counter = `LEASE_CYCLES`−1, pulse `lease_expired`, clear `rearm`, and go to `TO_CAM`.
- **rearm**: set whenever `nios_req`=0 is sampled. An expired Nios must drop its request for at least one cycle before it can be granted again.
- **Ack timeout**: in `TO_NIOS` or `TO_CAM`, a wait counter runs. At `ACK_TIMEOUT` cycles without the acknowledge, set `ack_error` and keep waiting. The request level does not change.
- **Request dropped during TO_NIOS**: finish the handover, enter `NIOS_RUN` for one cycle with `nios_grant`=1, then go to `TO_CAM`.
- **Simultaneous `nios_req` fall and lease expiry**: the release wins; no `lease_expired` pulse.

## Timing
- All outputs are registered.
- `nios_grant` rises the cycle after `NiosHasControl` is sampled high.
- `nios_grant` falls the cycle after the release or expiry decision, in the same cycle `RequestNiosControl` falls.
- `cam_pause` rises the cycle after the `cam_frame_end` pulse is sampled in `CAM_DRAIN`.
- `cam_pause` falls the cycle after `CamHasControl` is sampled high in `TO_CAM`.
- Arbiter round trip is 3 cycles each way, so nominal switch latency from drain-complete to `nios_grant` is 4 cycles.
- `Reset` asserted mid-lease: `nios_grant` and `RequestNiosControl` drop asynchronously; the arbiter then returns to camera via `TO_CAM`.

## Structure
- Shared package `sdram_arb_pkg`: state enum `handover_state_t`, default parameter constants, `HANDOVER_CNT_W`=8.
- One natural sub-module, `sat_cycle_counter`: clear, enable, saturate limit, terminal-count flag. Instantiated once for the camera-minimum and lease counts, once for the ack wait.

## Test plan
- **Reset release**, `CamHasControl` rises 3 cycles later → `CAM_RUN`; `cam_pause` falls at cycle 4; all other outputs 0.
- **Normal handover**: `MIN_CAM_CYCLES`=8; `nios_req` at cycle 2, `cam_frame_end` at cycle 20, `cam_idle` high → `RequestNiosControl` rises at 21, `nios_grant` rises 1 cycle after `NiosHasControl`, `handover_count`=1.
- **Lease expiry**: `LEASE_CYCLES`=16, `nios_req` held → `lease_expired` pulses once; `nios_grant` is high for exactly 16 cycles; no regrant until `nios_req` toggles low→high.
- **Abort in drain**: `nios_req` drops before `cam_frame_end` → back to `CAM_RUN`, `cam_pause`=0, `RequestNiosControl` never rises.
- **Ack timeout**: `NiosHasControl` held low → `ack_error` set at cycle 15 of `TO_NIOS` and stays set; later acknowledge still completes the handover.
- **Async reset** mid-`NIOS_RUN` → `nios_grant`=0 and `RequestNiosControl`=0 immediately, before the next edge; `handover_count`=0.
